// File: rtl/hex_counter_display.sv
// Up/down counter with prescaler, modulus wrap, parallel load and terminal-count pulse.
// Each nibble of the count drives one active-low 7-segment digit.
module hex_counter_display #(
  parameter int              DIGITS   = 4,
  parameter longint unsigned MODULUS  = 0,
  parameter int              PRESCALE = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam bit FULL = (MODULUS == 0);
  localparam logic [W:0]    MOD_VAL  = FULL ? {1'b1, {W{1'b0}}} : (W+1)'(MODULUS);
  localparam logic [W-1:0]  MAX_VAL  = W'(MOD_VAL - 1'b1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          step;
  logic          load_ok;
  logic          at_max;
  logic          at_zero;

  assign step    = enable && (presc == PRE_LAST);
  assign load_ok = ({1'b0, load_value} < MOD_VAL);
  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);

  // Full-range wrap falls out of natural W-bit overflow, so only a finite modulus needs the compare.
  always_ff @(posedge clock) begin
    if (!clear) begin
      count <= '0;
      presc <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_ok ? load_value : '0;
      presc <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (enable) begin
        presc <= step ? '0 : presc + 1'b1;
      end
      if (step) begin
        if (up) begin
          count <= (!FULL && at_max) ? '0 : count + 1'b1;
          tc    <= at_max;
        end else begin
          count <= (!FULL && at_zero) ? MAX_VAL : count - 1'b1;
          tc    <= at_zero;
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign hex[7*k+6:7*k] = seg7(count[4*k+3:4*k]);
  end

endmodule

// File: tb/tb_hex_counter_display.sv
// Directed bench for hex_counter_display: four instances with different parameter sets
// share one input bus; each scenario checks only the instance it targets.
module tb_hex_counter_display;

  logic        clock;
  logic        clear;
  logic        enable;
  logic        up;
  logic        load;
  logic [15:0] load_value;

  logic [15:0] count_a;  logic tc_a;  logic [27:0] hex_a;
  logic [3:0]  count_b;  logic tc_b;  logic [6:0]  hex_b;
  logic [7:0]  count_c;  logic tc_c;  logic [13:0] hex_c;
  logic [15:0] count_d;  logic tc_d;  logic [27:0] hex_d;

  int total = 0;
  int bad   = 0;

  hex_counter_display #(.DIGITS(4), .MODULUS(0), .PRESCALE(1)) dut_a (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(count_a), .tc(tc_a), .hex(hex_a));

  hex_counter_display #(.DIGITS(1), .MODULUS(10), .PRESCALE(3)) dut_b (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value[3:0]), .count(count_b), .tc(tc_b), .hex(hex_b));

  hex_counter_display #(.DIGITS(2), .MODULUS(10), .PRESCALE(4)) dut_c (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value[7:0]), .count(count_c), .tc(tc_c), .hex(hex_c));

  hex_counter_display #(.DIGITS(4), .MODULUS(0), .PRESCALE(4)) dut_d (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(count_d), .tc(tc_d), .hex(hex_d));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        clear;
    logic        enable;
    logic        up;
    logic        load;
    logic [15:0] value;
    logic [15:0] exp_count;
    logic        exp_tc;
  } vec_t;

  vec_t       vecs [20];
  logic [6:0] seg_tab [16];

  task automatic applyStimulus(input logic cl, input logic en, input logic dir,
                               input logic ld, input logic [15:0] val);
    clear      = cl;
    enable     = en;
    up         = dir;
    load       = ld;
    load_value = val;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [27:0] hex4(input logic [15:0] c);
    return {seg_tab[c[15:12]], seg_tab[c[11:8]], seg_tab[c[7:4]], seg_tab[c[3:0]]};
  endfunction

  initial begin
    seg_tab[0]  = 7'b1000000;  seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100;  seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001;  seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010;  seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000;  seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000;  seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110;  seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110;  seg_tab[15] = 7'b0001110;

    // clear, enable, up, load, value, expected count, expected tc  (instance a)
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h89AB, 16'h89AB, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hCDEF, 16'hCDEF, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h4567, 16'h4567, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h4568, 1'b0};

    clear = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = 16'h0000;
    #2;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].clear, vecs[i].enable, vecs[i].up, vecs[i].load, vecs[i].value);
      checkOutput($sformatf("a_count[%0d]", i), 32'(count_a), 32'(vecs[i].exp_count));
      checkOutput($sformatf("a_tc[%0d]", i),    32'(tc_a),    32'(vecs[i].exp_tc));
      checkOutput($sformatf("a_hex[%0d]", i),   32'(hex_a),   32'(hex4(vecs[i].exp_count)));
    end

    // Decimal modulus, count down through a prescale of 3.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("b_clear_count", 32'(count_b), 32'd0);
    checkOutput("b_clear_hex",   32'(hex_b),   32'h40);
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("b_count[%0d]", e), 32'(count_b),
                  (e < 3) ? 32'd0 : (e < 6) ? 32'd9 : 32'd8);
      checkOutput($sformatf("b_tc[%0d]", e), 32'(tc_b), (e == 3) ? 32'd1 : 32'd0);
      if (e == 3) checkOutput("b_hex_9", 32'(hex_b), 32'(7'b0010000));
    end

    // Load takes priority over a step that is due, and out-of-range loads clamp to 0.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int e = 0; e < 3; e++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("c_before_load", 32'(count_c), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0007);
    checkOutput("c_load7_count", 32'(count_c), 32'd7);
    checkOutput("c_load7_tc",    32'(tc_c),    32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h000C);
    checkOutput("c_load12", 32'(count_c), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0009);
    checkOutput("c_load9", 32'(count_c), 32'd9);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h000A);
    checkOutput("c_load10", 32'(count_c), 32'd0);

    // Enable gating: 2 on, 3 off, 2 on gives exactly one step on the 4th enabled edge.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("c_gate_en2", 32'(count_c), 32'd0);
    for (int e = 0; e < 3; e++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("c_gate_off", 32'(count_c), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("c_gate_en3", 32'(count_c), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("c_gate_en4", 32'(count_c), 32'd1);

    // Direction flip with the prescaler at 2: next step goes down, two enabled edges later.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("c_flip_wait", 32'(count_c), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("c_flip_step", 32'(count_c), 32'd0);
    checkOutput("c_flip_tc",   32'(tc_c),    32'd0);
    for (int e = 0; e < 4; e++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("c_down_wrap",    32'(count_c), 32'd9);
    checkOutput("c_down_wrap_tc", 32'(tc_c),    32'd1);
    checkOutput("c_down_wrap_hex", 32'(hex_c), 32'({7'b1000000, 7'b0010000}));

    // Reset mid-count with the prescaler nonzero and load asserted.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("d_pre_reset", 32'(count_d), 32'h1234);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h5555);
    checkOutput("d_reset_count", 32'(count_d), 32'd0);
    checkOutput("d_reset_tc",    32'(tc_d),    32'd0);
    checkOutput("d_reset_hex",   32'(hex_d),   32'h8102040);
    for (int e = 1; e <= 4; e++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      checkOutput($sformatf("d_after[%0d]", e), 32'(count_d), (e < 4) ? 32'd0 : 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
